uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the maximum data word width in bits.
REQ-002 The block SHALL have parameter CLK_FREQ, default 100_000_000, giving the clk frequency in Hz.
REQ-003 The block SHALL have parameter BAUD_RATE, default 9600, giving the serial bit rate in bits per second.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1 bit: the reset, which SHALL be synchronous and active-high.
REQ-006 Port tx_data, input, DATA_WIDTH bits: the word to send, LSB first.
REQ-007 Port tx_valid, input, 1 bit: a send request.
REQ-008 Port tx_ready, output, 1 bit: high when the block can accept a word.
REQ-009 Port parity_en, input, 1 bit: when high, an even parity bit SHALL follow the data bits.
REQ-010 Port two_stop_bits, input, 1 bit: when high, two stop bits SHALL be sent; otherwise one.
REQ-011 Port word_length, input, 2 bits: 00 selects 5 data bits, 01 selects 6, 10 selects 7, 11 selects 8.
REQ-012 Port tx, output, 1 bit: the serial line, idle high.
REQ-013 Port tx_busy, output, 1 bit: high while a frame is in progress.
REQ-014 Port tx_done, output, 1 bit: a one-cycle pulse at the end of each frame.

Function
REQ-015 The bit period SHALL be CLKS_PER_BIT = CLK_FREQ/BAUD_RATE clk cycles, with integer truncation (10416 at the defaults).
REQ-016 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-017 A word SHALL be accepted on a cycle where tx_valid and tx_ready are both high.
REQ-018 tx_ready SHALL be high only in IDLE.
REQ-019 On acceptance, the block SHALL latch tx_data, parity_en, two_stop_bits and word_length; input changes mid-frame SHALL NOT affect the frame in progress.
REQ-020 tx SHALL be a registered output that goes low (start bit) on the cycle after acceptance.
REQ-021 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles.
REQ-022 Frame order SHALL be: start bit (0), N data bits LSB first, optional parity bit, stop1 (1), optional stop2 (1).
REQ-023 The parity bit SHALL be the XOR of the N transmitted data bits only; data bits above N SHALL be ignored.
REQ-024 State transitions: IDLE->START on acceptance; START->DATA; DATA->PARITY after bit N-1 if parity is enabled, otherwise DATA->STOP1; PARITY->STOP1; STOP1->STOP2 if two stop bits are selected, otherwise STOP1->IDLE; STOP2->IDLE.
REQ-025 tx_done SHALL pulse for one cycle, coincident with the return to IDLE, after the final stop bit has completed its full period.
REQ-026 tx_ready SHALL rise on that same cycle, so that back-to-back frames have no idle gap beyond one cycle.
REQ-027 tx_busy SHALL equal the inverse of tx_ready.
REQ-028 tx_valid SHALL be ignored while busy, with no queuing.
REQ-029 The bit counter SHALL be 3 bits wide and the baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide; neither SHALL wrap within a frame.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL force state IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, and clear all counters and the shift register.
REQ-031 If rst is asserted mid-frame, the frame SHALL be aborted, tx SHALL return high on the next edge, and no tx_done SHALL be produced.
REQ-032 A tx_valid that is high in the same cycle as rst SHALL be ignored.

Structure
REQ-033 The state encoding, the word_length codes and a function mapping word_length to a bit count (5-8) SHALL be placed in a shared package uart_pkg, so the receiver can reuse them.
REQ-034 The baud counter SHALL be a sub-module uart_baud_gen, with inputs clk, rst and an enable, and a one-cycle output tick that fires every CLKS_PER_BIT cycles; its count SHALL restart when enable goes low.

Verification
REQ-035 Send 0x55, 8 bits, no parity, 1 stop -> tx shows 0,1,0,1,0,1,0,1,0,1 at 10416-cycle spacing; tx_done 104160 cycles after acceptance.
REQ-036 Send 0x41, 8 bits, parity enabled -> parity bit=0; send 0x43 -> parity bit=1.
REQ-037 Send 0xAA, 8 bits, 2 stop -> line high for 20832 cycles after bit 7; total frame is 11 bit periods.
REQ-038 Send 0xEF, 5-bit word_length, parity enabled -> data bits 1,1,1,1,0, then parity 0; upper bits are not sent.
REQ-039 Hold tx_valid high for two words -> second start bit begins one cycle after the first tx_done; tx_data changes mid-frame are ignored.
REQ-040 Assert rst during data bit 3 -> tx=1, tx_ready=1 on the next edge, and no tx_done pulse.
REQ-041 Loopback tx into uart_receiver for all four word lengths -> data_valid with matching data, and parity_error=0, frame_error=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, word-length codes and code-to-bit-count mapping.
// Kept separate so the matching receiver decodes frames with identical encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_state_t;

    typedef enum logic [1:0] {
        WL_5BIT = 2'b00,
        WL_6BIT = 2'b01,
        WL_7BIT = 2'b10,
        WL_8BIT = 2'b11
    } word_len_t;

    function automatic logic [3:0] word_bits(input word_len_t wl);
        logic [3:0] n;
        case (wl)
            WL_5BIT: n = 4'd5;
            WL_6BIT: n = 4'd6;
            WL_7BIT: n = 4'd7;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick is a one-cycle strobe every CLKS_PER_BIT enabled cycles, zero latency.
// No backpressure; the count restarts from zero whenever enable drops.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit on tx the cycle after tx_valid&&tx_ready, tx_done as the line returns to idle.
// Accepts only in IDLE (tx_ready); tx_valid while busy is dropped, nothing is queued.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  parity_en,
    input  logic                  two_stop_bits,
    input  logic [1:0]            word_length,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

    uart_state_t           state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [2:0]            bit_cnt, bit_cnt_nxt;
    logic [2:0]            last_bit;
    word_len_t             wl_q;
    logic                  par_en_q, two_stop_q, parity_q;
    logic                  tx_nxt, done_nxt, load, shift;
    logic                  baud_en, baud_tick, par_in;

    assign tx_ready = (state == IDLE);
    assign tx_busy  = ~tx_ready;
    assign baud_en  = (state != IDLE);
    assign last_bit = 3'(word_bits(wl_q) - 4'd1);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (baud_en),
        .tick   (baud_tick)
    );

    // Parity is taken over the selected word length only, at acceptance time.
    always_comb begin
        par_in = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(word_bits(word_len_t'(word_length)))) begin
                par_in = par_in ^ tx_data[i];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx;
        done_nxt    = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (tx_valid) begin
                    state_nxt   = START;
                    tx_nxt      = 1'b0;
                    load        = 1'b1;
                    bit_cnt_nxt = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shreg[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == last_bit) begin
                        state_nxt = par_en_q ? PARITY : STOP1;
                        tx_nxt    = par_en_q ? parity_q : 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        shift       = 1'b1;
                        tx_nxt      = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_nxt = STOP1;
                    tx_nxt    = 1'b1;
                end
            end
            STOP1: begin
                if (baud_tick) begin
                    state_nxt = two_stop_q ? STOP2 : IDLE;
                    done_nxt  = ~two_stop_q;
                    tx_nxt    = 1'b1;
                end
            end
            STOP2: begin
                if (baud_tick) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            wl_q       <= WL_8BIT;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            parity_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx      <= tx_nxt;
            tx_done <= done_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (load) begin
                shreg      <= tx_data;
                wl_q       <= word_len_t'(word_length);
                par_en_q   <= parity_en;
                two_stop_q <= two_stop_bits;
                parity_q   <= par_in;
            end else if (shift) begin
                shreg <= shreg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a 10-cycle bit period (125/12 truncated).
// Expected frames are hand-built vectors, bit 0 = first bit on the line.
module tb_uart_transmitter;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       parity_en;
    logic       two_stop_bits;
    logic [1:0] word_length;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_transmitter #(
        .DATA_WIDTH (8),
        .CLK_FREQ   (125),
        .BAUD_RATE  (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .parity_en     (parity_en),
        .two_stop_bits (two_stop_bits),
        .word_length   (word_length),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one word, scrambles the inputs mid-frame and checks every cycle of the frame.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] wl,
                             input logic pe, input logic ts, input int nbits,
                             input logic [15:0] exp, input logic hold_valid, output int waited);
        int         hold_err;
        int         done_err;
        logic [15:0] got;
        hold_err = 0;
        done_err = 0;
        got      = '0;
        waited   = 0;
        while (!tx_ready && waited < 300) begin
            step();
            waited++;
        end
        check({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
        tx_data       = d;
        word_length   = wl;
        parity_en     = pe;
        two_stop_bits = ts;
        tx_valid      = 1'b1;
        step();
        check({tag, "_start"}, {29'd0, tx_busy, tx_ready, tx}, 32'b100);
        tx_data       = ~d;
        word_length   = ~wl;
        parity_en     = ~pe;
        two_stop_bits = ~ts;
        tx_valid      = hold_valid;
        for (int t = 0; t < nbits * CPB; t++) begin
            if (tx !== exp[t / CPB]) hold_err++;
            if (tx_done !== 1'b0) done_err++;
            if (t % CPB == CPB / 2) got[t / CPB] = tx;
            step();
        end
        check({tag, "_bits"}, {16'd0, got}, {16'd0, exp});
        check({tag, "_timing"}, hold_err, 0);
        check({tag, "_early_done"}, done_err, 0);
        check({tag, "_done"}, {29'd0, tx_done, tx_ready, tx}, 32'b111);
        if (!hold_valid) begin
            step();
            check({tag, "_pulse"}, {31'd0, tx_done}, 32'd0);
        end
    endtask

    initial begin
        int waited;
        int err;

        rst           = 1'b1;
        tx_valid      = 1'b1;
        tx_data       = 8'hFF;
        word_length   = 2'b11;
        parity_en     = 1'b0;
        two_stop_bits = 1'b0;
        repeat (3) step();
        check("reset", {28'd0, tx_done, tx_busy, tx_ready, tx}, 32'b0011);
        rst      = 1'b0;
        tx_valid = 1'b0;
        step();
        check("idle", {28'd0, tx_done, tx_busy, tx_ready, tx}, 32'b0011);

        run_frame("f55", 8'h55, 2'b11, 1'b0, 1'b0, 10, 16'h02AA, 1'b0, waited);
        run_frame("f41", 8'h41, 2'b11, 1'b1, 1'b0, 11, 16'h0482, 1'b0, waited);
        run_frame("f43", 8'h43, 2'b11, 1'b1, 1'b0, 11, 16'h0686, 1'b0, waited);
        run_frame("fAA", 8'hAA, 2'b11, 1'b0, 1'b1, 11, 16'h0754, 1'b0, waited);
        run_frame("fEF", 8'hEF, 2'b00, 1'b1, 1'b0,  8, 16'h009E, 1'b0, waited);
        run_frame("fED", 8'hED, 2'b01, 1'b0, 1'b0,  8, 16'h00DA, 1'b0, waited);
        run_frame("fDB", 8'hDB, 2'b10, 1'b1, 1'b1, 11, 16'h07B6, 1'b0, waited);

        // tx_valid held through the first frame; the second must start right after tx_done.
        run_frame("b2b1", 8'h55, 2'b11, 1'b0, 1'b0, 10, 16'h02AA, 1'b1, waited);
        run_frame("b2b2", 8'h43, 2'b11, 1'b1, 1'b0, 11, 16'h0686, 1'b0, waited);
        check("b2b_gap", waited, 0);

        tx_data       = 8'h55;
        word_length   = 2'b11;
        parity_en     = 1'b0;
        two_stop_bits = 1'b0;
        tx_valid      = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int t = 0; t < 4 * CPB + 3; t++) step();
        check("abort_pre", {30'd0, tx_busy, tx}, 32'b10);
        rst      = 1'b1;
        tx_valid = 1'b1;
        step();
        check("abort_rst", {28'd0, tx_done, tx_busy, tx_ready, tx}, 32'b0011);
        rst      = 1'b0;
        tx_valid = 1'b0;
        err      = 0;
        for (int t = 0; t < 12 * CPB; t++) begin
            if (tx !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b1) err++;
            step();
        end
        check("abort_quiet", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
